// File: rtl/bcd_counter_n_pkg.sv
// Shared constants for the packed-BCD counter: active-low 7-segment glyphs (g..a) and BCD limits.
package bcd_counter_n_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Clamp an out-of-range nibble to the largest BCD digit.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_counter_n_seg7_decode.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes and blank render dark.
module seg7_decode
    import bcd_counter_n_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// Prescaled up/down packed-BCD counter with clear/load, step and wrap pulses, and 7-segment outputs.
module bcd_counter_n
    import bcd_counter_n_pkg::*;
#(
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned DIV      = 50000000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    En,
    input  logic                    Up,
    input  logic                    Clear,
    input  logic                    Load,
    input  logic [4*DIGITS-1:0]     LoadVal,
    output logic [4*DIGITS-1:0]     Count,
    output logic                    Tick,
    output logic                    Tc,
    output logic [7*DIGITS-1:0]     HEX
);

    localparam int unsigned CW = BCD_W * DIGITS;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]     presc;
    logic              step_c;
    logic              wrap_c;
    logic [DIGITS-1:0] at_lim_c;
    logic [DIGITS-1:0] cin_c;
    logic [DIGITS-1:0] nz_c;
    logic [DIGITS-1:0] blank_c;
    logic [CW-1:0]     next_c;
    logic [CW-1:0]     load_c;

    assign step_c = En && (presc == PRESC_LAST);
    assign wrap_c = &at_lim_c;

    // Per-digit carry/borrow: a digit moves only when every lower digit sits at its wrap limit.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [BCD_W-1:0] d;
        logic [BCD_W-1:0] nd;

        assign d           = Count[BCD_W*k +: BCD_W];
        assign at_lim_c[k] = Up ? (d == BCD_MAX) : (d == 4'd0);
        assign nz_c[k]     = (d != 4'd0);

        if (k == 0) begin : g_lsd
            assign cin_c[k] = 1'b1;
        end else begin : g_upper
            assign cin_c[k] = cin_c[k-1] & at_lim_c[k-1];
        end

        assign nd = !cin_c[k]   ? d :
                    at_lim_c[k] ? (Up ? 4'd0 : BCD_MAX) :
                    Up          ? d + 4'd1 : d - 4'd1;

        assign next_c[BCD_W*k +: BCD_W] = nd;
        assign load_c[BCD_W*k +: BCD_W] = bcd_sat(LoadVal[BCD_W*k +: BCD_W]);

        // Leading-zero blanking keeps digit 0 lit so a zero count still shows "0".
        assign blank_c[k] = BLANK_LZ && (k != 0) && ((nz_c >> k) == '0);

        seg7_decode u_seg (
            .bcd   (d),
            .blank (blank_c[k]),
            .seg   (HEX[SEG_W*k +: SEG_W])
        );
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc <= '0;
            Count <= '0;
            Tick  <= 1'b0;
            Tc    <= 1'b0;
        end else if (Clear) begin
            presc <= '0;
            Count <= '0;
            Tick  <= 1'b0;
            Tc    <= 1'b0;
        end else if (Load) begin
            presc <= '0;
            Count <= load_c;
            Tick  <= 1'b0;
            Tc    <= 1'b0;
        end else if (En) begin
            Tick <= step_c;
            Tc   <= step_c && wrap_c;
            if (step_c) begin
                presc <= '0;
                Count <= next_c;
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            Tick <= 1'b0;
            Tc   <= 1'b0;
        end
    end

endmodule
